// File: rtl/prio_arbiter_rr.sv
// Registered N-way arbiter with runtime-selectable fixed-priority (MSB wins) or round-robin
// arbitration, plus optional grant locking bounded by a hold-time limit.
module prio_arbiter_rr #(
    parameter int unsigned N        = 8,
    parameter int unsigned LOCK     = 1,
    parameter int unsigned MAX_HOLD = 4,
    localparam int unsigned W       = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] req,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_oh,
    output logic         valid
);

    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e         state_q;
    logic [W-1:0]   ptr_q;
    logic [HW-1:0]  hold_cnt_q;
    logic [W-1:0]   grant_idx_q;
    logic [N-1:0]   grant_oh_q;
    logic           valid_q;

    logic [W-1:0]   fp_win;
    logic [W-1:0]   rr_win;
    logic           rr_found;
    logic [W-1:0]   win;
    logic [N-1:0]   win_oh;
    logic           any_req;
    logic           holder_req;
    logic           arbitrate;

    // Fixed priority: the last matching index in an ascending scan is the highest set bit.
    always_comb begin
        fp_win = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i]) begin
                fp_win = W'(i);
            end
        end
    end

    // Round-robin: descend from ptr-1, wrapping, so the last winner is checked last.
    always_comb begin
        rr_win   = '0;
        rr_found = 1'b0;
        for (int off = 1; off <= int'(N); off++) begin
            int idx;
            idx = (int'(ptr_q) + int'(N) - off) % int'(N);
            if (!rr_found && req[idx]) begin
                rr_win   = W'(idx);
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        win        = mode ? rr_win : fp_win;
        win_oh     = {{(N-1){1'b0}}, 1'b1} << win;
        any_req    = |req;
        holder_req = req[grant_idx_q];
        arbitrate  = (state_q == StIdle) || (LOCK == 0) || !holder_req ||
                     (hold_cnt_q == HW'(MAX_HOLD));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            valid_q     <= 1'b0;
        end else if (!en) begin
            // ptr survives a disable so round-robin fairness resumes where it left off.
            state_q     <= StIdle;
            hold_cnt_q  <= '0;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            valid_q     <= 1'b0;
        end else if (arbitrate) begin
            if (!any_req) begin
                state_q     <= StIdle;
                hold_cnt_q  <= '0;
                grant_idx_q <= '0;
                grant_oh_q  <= '0;
                valid_q     <= 1'b0;
            end else begin
                state_q     <= StGrant;
                ptr_q       <= win;
                hold_cnt_q  <= HW'(1);
                grant_idx_q <= win;
                grant_oh_q  <= win_oh;
                valid_q     <= 1'b1;
            end
        end else begin
            // Holding: arbitrate already fires at MAX_HOLD, so this never exceeds it.
            hold_cnt_q <= hold_cnt_q + HW'(1);
        end
    end

    assign grant_idx = grant_idx_q;
    assign grant_oh  = grant_oh_q;
    assign valid     = valid_q;

    a_idle_no_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !valid_q |-> (grant_oh_q == '0));
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        valid_q |-> $onehot(grant_oh_q));
    a_oh_matches_idx: assert property (@(posedge clk) disable iff (!rst_n)
        valid_q |-> grant_oh_q[grant_idx_q]);

endmodule
